// File: rtl/pin_id_tx.sv
// rtl/pin_id_tx.sv - pin bank where every pin serially transmits its own index
//
// Purpose:
//   Each bit k of `pins` repeatedly sends a frame identifying index k, so a
//   probe on any board trace shows which FPGA pin drives it. All pins share one
//   frame timer. Frame: SYNC (4 slots 1,0,1,0), INDEX (IDX_W slots, MSB first),
//   PARITY (1 slot, ~^k), GAP (GAP_CYCLES low). Each slot is BIT_CYCLES clocks.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       level; start or continue framing
//   pins         NUM_PINS registered outputs; bit k carries the frame for index k
//   frame_start  one-cycle pulse with the first SYNC cycle on pins
//   busy         high from the first SYNC cycle through the last GAP cycle
//   frame_count  frames started, wraps at 16 bits
//
// Configuration:
//   PIN_ID_MANCHESTER_EN  defined: each slot is Manchester coded (inverted bit
//                         in the first half, true bit in the second half).
//                         undefined: NRZ, bit held for the whole slot.

module pin_id_tx #(
    parameter int NUM_PINS   = 401,
    parameter int IDX_W      = 9,
    parameter int BIT_CYCLES = 16,
    parameter int GAP_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic [NUM_PINS-1:0] pins,
    output logic                frame_start,
    output logic                busy,
    output logic [15:0]         frame_count
);

    localparam int TMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int SW   = $clog2(IDX_W + 4);

    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] HALF     = TW'(BIT_CYCLES / 2);
    localparam logic [SW-1:0] SYNC_LAST = SW'(3);
    localparam logic [SW-1:0] IDX_LAST  = SW'(IDX_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_INDEX  = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    generate
        if ((2 ** IDX_W) < NUM_PINS) begin : g_chk_idx_w
            $fatal(1, "pin_id_tx: IDX_W too small for NUM_PINS");
        end
        if ((BIT_CYCLES < 2) || ((BIT_CYCLES % 2) != 0)) begin : g_chk_bit_cycles
            $fatal(1, "pin_id_tx: BIT_CYCLES must be even and >= 2");
        end
        if (GAP_CYCLES < 1) begin : g_chk_gap_cycles
            $fatal(1, "pin_id_tx: GAP_CYCLES must be >= 1");
        end
    endgenerate

    logic [2:0]          state, nxt_state;
    logic [TW-1:0]       timer, nxt_timer;
    logic [SW-1:0]       slot,  nxt_slot;
    logic                start;

    logic [IDX_W-1:0]    idx_sel;
    logic                in_slot;
    logic                sync_one;
    logic                par_en;
    logic                first_half;
    logic [NUM_PINS-1:0] pin_nxt;

    // Shared frame sequencer. The timer counts within a slot (or across the
    // whole GAP); the slot counter restarts at each state change.
    always_comb begin
        nxt_state = state;
        nxt_timer = timer;
        nxt_slot  = slot;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    nxt_state = S_SYNC;
                    nxt_timer = '0;
                    nxt_slot  = '0;
                    start     = 1'b1;
                end
            end
            S_SYNC, S_INDEX, S_PARITY: begin
                if (timer == BIT_LAST) begin
                    nxt_timer = '0;
                    if ((state == S_SYNC) && (slot == SYNC_LAST)) begin
                        nxt_state = S_INDEX;
                        nxt_slot  = '0;
                    end else if ((state == S_INDEX) && (slot == IDX_LAST)) begin
                        nxt_state = S_PARITY;
                        nxt_slot  = '0;
                    end else if (state == S_PARITY) begin
                        nxt_state = S_GAP;
                        nxt_slot  = '0;
                    end else begin
                        nxt_slot  = slot + SW'(1);
                    end
                end else begin
                    nxt_timer = timer + TW'(1);
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    nxt_timer = '0;
                    nxt_slot  = '0;
                    if (enable) begin
                        nxt_state = S_SYNC;
                        start     = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end else begin
                    nxt_timer = timer + TW'(1);
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_timer = '0;
                nxt_slot  = '0;
            end
        endcase
    end

    // Decode of the upcoming cycle, shared by every pin. Pins are registered
    // from these so the pin value lines up with the state it belongs to.
    always_comb begin
        idx_sel = '0;
        for (int j = 0; j < IDX_W; j++) begin
            // One-hot select of the index bit currently on the wire (MSB first).
            idx_sel[j] = (nxt_state == S_INDEX) && (nxt_slot == SW'(IDX_W - 1 - j));
        end
        in_slot  = (nxt_state == S_SYNC) || (nxt_state == S_INDEX) || (nxt_state == S_PARITY);
        sync_one = (nxt_state == S_SYNC) && !nxt_slot[0];
        par_en   = (nxt_state == S_PARITY);
`ifdef PIN_ID_MANCHESTER_EN
        first_half = (nxt_timer < HALF);
`else
        first_half = 1'b0;
`endif
    end

    // Per-pin logic uses only elaboration-time constants for the index and
    // its parity; the only runtime state is the shared sequencer above.
    generate
        for (genvar k = 0; k < NUM_PINS; k++) begin : g_pin
            localparam logic [IDX_W-1:0] KV  = IDX_W'(k);
            localparam logic             PAR = ~^KV;
            assign pin_nxt[k] = in_slot &
                ((sync_one | (|(KV & idx_sel)) | (par_en & PAR)) ^ first_half);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            slot        <= '0;
            pins        <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            state       <= nxt_state;
            timer       <= nxt_timer;
            slot        <= nxt_slot;
            pins        <= pin_nxt;
            frame_start <= start;
            busy        <= (nxt_state != S_IDLE);
            if (start) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pin_id_tx.sv
// tb/tb_pin_id_tx.sv - self-checking bench for pin_id_tx against a frame-offset model

module tb_pin_id_tx;

    localparam int NP = 401;
    localparam int IW = 9;
    localparam int B  = 16;
    localparam int G  = 32;
    localparam int DATA_LEN = (5 + IW) * B;
    localparam int L  = DATA_LEN + G;
`ifdef PIN_ID_MANCHESTER_EN
    localparam bit MANCH = 1'b1;
`else
    localparam bit MANCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [NP-1:0] pins;
    logic          frame_start;
    logic          busy;
    logic [15:0]   frame_count;

    pin_id_tx #(.NUM_PINS(NP), .IDX_W(IW), .BIT_CYCLES(B), .GAP_CYCLES(G)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pins        (pins),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc++;

    // Model: position within the current frame (-1 when idle) and frames started.
    int          mpos = -1;
    logic [15:0] mcount = 16'h0000;
    logic [15:0] ofs = 16'h0000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mpos   = -1;
            mcount = 16'h0000;
        end else if (mpos < 0) begin
            if (enable) begin
                mpos = 0;
                mcount = mcount + 16'd1;
            end
        end else if (mpos == L - 1) begin
            if (enable) begin
                mpos = 0;
                mcount = mcount + 16'd1;
            end else begin
                mpos = -1;
            end
        end else begin
            mpos = mpos + 1;
        end
    end

    function automatic logic exp_bit(int k, int pos);
        int slot;
        int ph;
        logic b;
        if (pos < 0 || pos >= DATA_LEN) return 1'b0;
        slot = pos / B;
        ph   = pos % B;
        if (slot < 4)            b = ((slot % 2) == 0);
        else if (slot < 4 + IW)  b = ((k >> (IW - 1 - (slot - 4))) & 1) != 0;
        else                     b = (($countones(k) % 2) == 0);
        if (MANCH && ph < B / 2) b = ~b;
        return b;
    endfunction

    function automatic logic [NP-1:0] exp_pins(int pos);
        logic [NP-1:0] v;
        for (int k = 0; k < NP; k++) v[k] = exp_bit(k, pos);
        return v;
    endfunction

    logic [NP-1:0] ep;
    logic [15:0]   ec;
    int            fd;

    always @(negedge clk) begin
        if (chk_on) begin
            ep = exp_pins(mpos);
            ec = mcount + ofs;
            vectors++;
            if (pins !== ep || frame_start !== (mpos == 0) || busy !== (mpos >= 0) ||
                frame_count !== ec) begin
                miscompares++;
                fd = 0;
                for (int k = NP - 1; k >= 0; k--) if (pins[k] !== ep[k]) fd = k;
                $display("FAIL model cycle %0d: pins[%0d]=%b want %b, frame_start=%b want %b, busy=%b want %b, frame_count=%h want %h",
                         cyc, fd, pins[fd], ep[fd], frame_start, (mpos == 0), busy, (mpos >= 0),
                         frame_count, ec);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Hand-written slot sequences: sync 1010, index, parity.
    logic [13:0] p5   = 14'b1010_000000101_1;
    logic [13:0] p0   = 14'b1010_000000000_1;
    logic [13:0] p400 = 14'b1010_110010000_0;

    // Entered at the negedge where frame_start should be high; walks one frame.
    task automatic walk_frame();
        int busy_n;
        int slot;
        int ph;
        logic e5, e0, e400;
        busy_n = 0;
        for (int o = 0; o < L; o++) begin
            if (o > 0) @(negedge clk);
            if (o == 0) chk("frame_start_latency", 32'(frame_start), 32'd1);
            if (busy) busy_n++;
            slot = o / B;
            ph   = o % B;
            if (slot < 14 && (ph == 0 || ph == B - 1)) begin
                e5 = p5[13 - slot];
                e0 = p0[13 - slot];
                e400 = p400[13 - slot];
                if (MANCH && ph == 0) begin
                    e5 = ~e5;
                    e0 = ~e0;
                    e400 = ~e400;
                end
                chk($sformatf("pin5_o%0d", o), 32'(pins[5]), 32'(e5));
                chk($sformatf("pin0_o%0d", o), 32'(pins[0]), 32'(e0));
                chk($sformatf("pin400_o%0d", o), 32'(pins[400]), 32'(e400));
            end
            if (o == L - 1) chk("gap_pins_low", 32'(|pins), 32'd0);
        end
        @(negedge clk);
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("busy_cycles", 32'(busy_n), 32'(L));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int st[3];
        int n;
        int c_en;
        logic [15:0] c0;
        bit done;
        int pct;

        // Reset held 5 cycles.
        repeat (5) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_pins", 32'(|pins), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single-cycle enable pulse.
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        walk_frame();
        chk("count_after_one", 32'(frame_count), 32'd1);

        // Enable held for three frames, dropped mid-frame 3.
        repeat (4) @(negedge clk);
        c0 = frame_count;
        enable = 1'b1;
        c_en = cyc;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (frame_start && n < 3) begin
                st[n] = cyc;
                n++;
            end
            if (n == 3 && cyc == st[2] + 100) enable = 1'b0;
            if (n == 3 && cyc > st[2] + 100 && !busy) done = 1'b1;
        end
        enable = 1'b0;
        chk("held_done", 32'(done), 32'd1);
        chk("held_starts", 32'(n), 32'd3);
        if (n == 3) begin
            chk("held_start0", 32'(st[0] - c_en), 32'd1);
            chk("held_start1", 32'(st[1] - c_en), 32'd257);
            chk("held_start2", 32'(st[2] - c_en), 32'd513);
            chk("held_frame3_len", 32'(cyc - st[2]), 32'(L));
        end
        chk("held_count", 32'(frame_count - c0), 32'd3);
        chk("held_idle_pins", 32'(|pins), 32'd0);

        // Randomized enable activity, checked by the model every cycle.
        for (int ph = 0; ph < 6; ph++) begin
            pct = $urandom_range(0, 100);
            repeat (500) begin
                @(negedge clk);
                enable = ($urandom_range(0, 99) < pct);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        wait_idle("random_idle");

        // frame_count wrap via preload.
        @(negedge clk);
        #2;
        force dut.frame_count = 16'hFFFF;
        ofs = 16'hFFFF - mcount;
        @(negedge clk);
        #2;
        release dut.frame_count;
        @(negedge clk);
        chk("preload_count", 32'(frame_count), 32'hFFFF);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("wrap_start", 32'(frame_start), 32'd1);
        chk("wrap_count", 32'(frame_count), 32'h0000);
        @(negedge clk);
        wait_idle("wrap_idle");

        // Asynchronous reset during INDEX, then a clean restart.
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        ofs = 16'h0000;
        #1;
        chk("async_reset_pins", 32'(|pins), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        walk_frame();
        chk("count_after_reset", 32'(frame_count), 32'd1);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pin_id_tx.md
Name: pin_id_tx

Overview:
- Output-side counterpart of the board pin-test input capture design.
- Drives a wide bank of FPGA output pins. Each pin serially transmits its own index in a framed pattern, so a probe or logic analyser on any board trace can tell which FPGA pin drives it.
- All pins transmit simultaneously and share one frame timer.
- Registered outputs drive top-level pins directly; no combinational path from inputs to pins.

Parameters:
- NUM_PINS, 401, number of driven output pins.
- IDX_W, 9, width of the transmitted index; must satisfy 2**IDX_W >= NUM_PINS (elaboration-time check, fatal on violation).
- BIT_CYCLES, 16, clocks per transmitted bit; must be >= 2 and even.
- GAP_CYCLES, 32, idle-low clocks after each frame; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; start or continue framing.
- pins  output  NUM_PINS  pin bank; bit k carries the frame for index k.
- frame_start  output  1  one-cycle pulse coincident with the first sync cycle on pins.
- busy  output  1  high from first SYNC cycle through last GAP cycle.
- frame_count  output  16  number of frames started; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset: pins=0, frame_start=0, busy=0, frame_count=0, state=IDLE, counters=0. Reset takes effect immediately (async), including mid-frame.
- Frame sent by pin k, per bit slot of BIT_CYCLES clocks:
  - SYNC: 4 slots, values 1,0,1,0.
  - INDEX: IDX_W slots, k[IDX_W-1:0] MSB first.
  - PARITY: 1 slot, value ~^k, i.e. odd parity over index+parity.
  - GAP: GAP_CYCLES clocks, low.
- Frame length = (5+IDX_W)*BIT_CYCLES + GAP_CYCLES. Defaults give 256 clocks.
- States: IDLE, SYNC, INDEX, PARITY, GAP.
  - IDLE -> SYNC when enable is sampled high.
  - SYNC -> INDEX after 4 slots.
  - INDEX -> PARITY after IDX_W slots.
  - PARITY -> GAP after 1 slot.
  - GAP -> SYNC if enable is high on the last GAP cycle; otherwise GAP -> IDLE.
- Latency: enable sampled high in IDLE at edge N -> first sync cycle on pins, frame_start=1, busy=1 at the cycle after edge N.
- frame_count increments in the same cycle frame_start is high.
- Bit timer counts 0..BIT_CYCLES-1. The slot counter advances when the timer wraps. No drift: each slot is exactly BIT_CYCLES clocks.
- enable dropped mid-frame: the current frame completes in full, including GAP, then IDLE. A frame is never truncated.
- enable held high: frames run back to back. frame_start period equals the frame length exactly.
- pins is all-zero in IDLE and GAP.
- Per-pin index values are elaboration constants. No per-pin runtime state is allowed beyond the shared shift position.

Optional Feature:
- Macro: PIN_ID_MANCHESTER_EN.
- Defined: each slot is Manchester coded. The first BIT_CYCLES/2 clocks carry the inverted bit, the second half carries the true bit (1 = low->high). GAP stays low. Frame length is unchanged.
- Undefined: NRZ; the bit value is held for the whole slot.

Test Plan:
- Reset held for 5 cycles -> pins=0, busy=0, frame_count=0. Assert reset during INDEX at cycle 100 -> pins=0 in the same cycle, IDLE. Re-enable -> the new frame starts at a clean SYNC.
- enable pulsed 1 cycle (default params, NRZ) -> frame_start at +1. pins[5] gives 16 cycles each of 1,0,1,0, then 0,0,0,0,0,0,1,0,1, then parity 1, then 32 low. busy high for exactly 256 cycles; frame_count=1.
- Same frame, other pins -> pins[0]: index all-zero, parity 1. pins[400]: index 110010000, parity 0. Every pin checked against an index/parity model.
- enable held for 3 frames, then dropped mid-frame 3 -> frame_start at cycles 1, 257, 513. Frame 3 completes fully; frame_count=3; then IDLE with pins=0.
- Preload frame_count to 0xFFFF via a bench force before a frame -> after frame_start it reads 0x0000.
- PIN_ID_MANCHESTER_EN defined -> pins[5] first sync slot is 8 cycles low then 8 high. First index slot (bit 0) is 8 high then 8 low. Total frame is still 256 cycles.
